// File: rtl/rom_loader_if.sv
// rom_loader_if: UART byte stream in, ROM write port out.
interface rom_loader_if;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  modport slave (input rx_valid_i, rx_data_i, output rx_ready_o, we_o, addr_o, data_o);
  modport master(output rx_valid_i, rx_data_i, input rx_ready_o, we_o, addr_o, data_o);
endinterface

// File: rtl/rom_loader.sv
// rom_loader: assembles a length-prefixed, checksummed byte stream into ROM word writes.
module rom_loader #(
  parameter int unsigned ROM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  rom_loader_if.slave  bus,
  output logic         busy_o,
  output logic         hold_cpu_o,
  output logic         done_o,
  output logic         err_o
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEN   = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] CSUM  = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] idx_q, idx_d, len_q, len_d, word_q, word_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]  sum_q, sum_d;
  logic        done_q, done_d, err_q, err_d, acc;
  assign acc = bus.rx_valid_i & bus.rx_ready_o;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    len_d   = len_q;
    word_d  = word_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sum_d   = sum_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = LEN;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = 2'd0;
        idx_d   = '0;
        len_d   = '0;
        word_d  = '0;
        sum_d   = '0;
      end
      LEN: if (acc) begin
        len_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = len_d > ROM_WORDS ? IDLE : len_d == '0 ? CSUM : DATA;
          err_d   = len_d > ROM_WORDS;
        end
      end
      DATA: if (acc) begin
        word_d[{cnt_q, 3'b000} +: 8] = bus.rx_data_i;
        sum_d = sum_q + bus.rx_data_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = WRITE;
          addr_d  = BASE_ADDR + {idx_q[29:0], 2'b00};
          data_d  = word_d;
        end
      end
      WRITE: begin
        idx_d   = idx_q + 32'd1;
        state_d = idx_d == len_q ? CSUM : DATA;
      end
      CSUM: if (acc) begin
        state_d = IDLE;
        done_d  = bus.rx_data_i == sum_q;
        err_d   = bus.rx_data_i != sum_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  assign bus.rx_ready_o = state_q == LEN || state_q == DATA || state_q == CSUM;
  assign bus.we_o       = state_q == WRITE;
  assign bus.addr_o     = addr_q;
  assign bus.data_o     = data_q;
  assign busy_o         = state_q != IDLE;
  assign hold_cpu_o     = busy_o;
  assign done_o         = done_q;
  assign err_o          = err_q;
endmodule
